// File: rtl/aes_seq_pkg.sv
// Shared definitions for the AES block sequencer and its watchdog.
package aes_seq_pkg;

    localparam int unsigned AES_SEQ_DATA_W  = 128;
    localparam int unsigned AES_SEQ_TIMEOUT = 64;
    localparam int unsigned AES_SEQ_CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } seq_state_e;

    // Counter width able to hold TIMEOUT-1; never narrower than one bit.
    function automatic int unsigned wd_width(input int unsigned timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/aes_seq_watchdog.sv
// Clearable cycle counter; expired_o is high while the count equals TIMEOUT-1.
module aes_seq_watchdog
    import aes_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = AES_SEQ_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned   CW   = wd_width(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and saturate at the last value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/aes_block_sequencer.sv
// Front-end sequencer for the AES-128 core: accepts a plaintext/key pair,
// starts the core, waits for completion under a watchdog and hands the
// ciphertext downstream. Counts completed output handshakes.
module aes_block_sequencer
    import aes_seq_pkg::*;
#(
    parameter int unsigned DATA_W  = AES_SEQ_DATA_W,
    parameter int unsigned TIMEOUT = AES_SEQ_TIMEOUT,
    parameter int unsigned CNT_W   = AES_SEQ_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_state,
    input  logic [DATA_W-1:0] in_key,
    output logic [DATA_W-1:0] state,
    output logic [DATA_W-1:0] key,
    output logic              core_start,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  blk_count
);

    seq_state_e        fsm_q;
    logic [DATA_W-1:0] state_q;
    logic [DATA_W-1:0] key_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              core_start_q;
    logic              timeout_err_q;
    logic [CNT_W-1:0]  blk_count_q;

    logic wd_clr;
    logic wd_en;
    logic wd_expired;

    // Watchdog is zeroed during START and runs only while waiting for the core.
    assign wd_clr = (fsm_q == START);
    assign wd_en  = (fsm_q == WAIT);

    aes_seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i     (clk),
        .rst_i     (rst),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    // Transaction FSM with registered datapath and pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q         <= IDLE;
            state_q       <= '0;
            key_q         <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            core_start_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            blk_count_q   <= '0;
        end else begin
            core_start_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q      <= in_state;
                        key_q        <= in_key;
                        core_start_q <= 1'b1;
                        fsm_q        <= START;
                    end
                end
                START: begin
                    fsm_q <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the expiry cycle takes priority over the abort.
                    if (core_done) begin
                        out_data_q  <= core_out;
                        out_valid_q <= 1'b1;
                        fsm_q       <= OUT;
                    end else if (wd_expired) begin
                        timeout_err_q <= 1'b1;
                        fsm_q         <= IDLE;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        blk_count_q <= blk_count_q + CNT_W'(1);
                        fsm_q       <= IDLE;
                    end
                end
                default: begin
                    fsm_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (fsm_q == IDLE);
    assign busy        = (fsm_q != IDLE);
    assign state       = state_q;
    assign key         = key_q;
    assign core_start  = core_start_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign timeout_err = timeout_err_q;
    assign blk_count   = blk_count_q;

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Directed bench for aes_block_sequencer: table of transactions plus
// hand-written watchdog, collision, streaming, reset and wrap sequences.
module tb_aes_block_sequencer;

    localparam int unsigned DW = 128;
    localparam int unsigned TO = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_state;
    logic [DW-1:0] in_key;
    logic [DW-1:0] state;
    logic [DW-1:0] key;
    logic          core_start;
    logic          core_done;
    logic [DW-1:0] core_out;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          timeout_err;
    logic [15:0]   blk_count;

    logic          d2_in_ready;
    logic [DW-1:0] d2_state;
    logic [DW-1:0] d2_key;
    logic          d2_core_start;
    logic          d2_out_valid;
    logic [DW-1:0] d2_out_data;
    logic          d2_busy;
    logic          d2_timeout_err;
    logic [1:0]    d2_blk_count;

    always #5 clk = ~clk;

    aes_block_sequencer #(
        .DATA_W  (DW),
        .TIMEOUT (TO),
        .CNT_W   (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_state    (in_state),
        .in_key      (in_key),
        .state       (state),
        .key         (key),
        .core_start  (core_start),
        .core_done   (core_done),
        .core_out    (core_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .timeout_err (timeout_err),
        .blk_count   (blk_count)
    );

    // Same stimulus, 2-bit block counter for the wrap check.
    aes_block_sequencer #(
        .DATA_W  (DW),
        .TIMEOUT (TO),
        .CNT_W   (2)
    ) dut2 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (d2_in_ready),
        .in_state    (in_state),
        .in_key      (in_key),
        .state       (d2_state),
        .key         (d2_key),
        .core_start  (d2_core_start),
        .core_done   (core_done),
        .core_out    (core_out),
        .out_valid   (d2_out_valid),
        .out_ready   (out_ready),
        .out_data    (d2_out_data),
        .busy        (d2_busy),
        .timeout_err (d2_timeout_err),
        .blk_count   (d2_blk_count)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [15:0] exp_cnt  = '0;

    typedef struct {
        logic [DW-1:0] pt;
        logic [DW-1:0] k;
        logic [DW-1:0] ct;
        int unsigned   lat;
        int unsigned   rdy;
    } vec_t;

    vec_t        vecs[4];
    logic [DW-1:0] sv[4];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_state"},       state, '0);
        chk({tag, "_key"},         key, '0);
        chk({tag, "_out_data"},    out_data, '0);
        chk({tag, "_out_valid"},   DW'(out_valid), '0);
        chk({tag, "_core_start"},  DW'(core_start), '0);
        chk({tag, "_timeout_err"}, DW'(timeout_err), '0);
        chk({tag, "_blk_count"},   DW'(blk_count), '0);
        chk({tag, "_in_ready"},    DW'(in_ready), DW'(1));
        chk({tag, "_busy"},        DW'(busy), '0);
        chk({tag, "_d2_blk_count"}, DW'(d2_blk_count), '0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = '0;
    endtask

    // One full transaction: accept, start, done after lat WAIT cycles,
    // out_ready held low for rdy OUT cycles, then handshake.
    task automatic do_txn(input logic [DW-1:0] pt, input logic [DW-1:0] k,
                          input logic [DW-1:0] ct, input int unsigned lat,
                          input int unsigned rdy);
        logic [1:0] exp2;
        in_state = pt;
        in_key   = k;
        in_valid = 1'b1;
        chk("txn_in_ready_idle", DW'(in_ready), DW'(1));
        tick();
        in_valid = 1'b0;
        in_state = ~pt;
        in_key   = ~k;
        chk("txn_state_latched", state, pt);
        chk("txn_key_latched", key, k);
        chk("txn_core_start_hi", DW'(core_start), DW'(1));
        chk("txn_in_ready_busy", DW'(in_ready), '0);
        tick();
        chk("txn_core_start_lo", DW'(core_start), '0);
        for (int unsigned i = 0; i < lat; i++) tick();
        chk("txn_no_out_before_done", DW'(out_valid), '0);
        core_done = 1'b1;
        core_out  = ct;
        tick();
        core_done = 1'b0;
        core_out  = ~ct;
        chk("txn_out_valid", DW'(out_valid), DW'(1));
        chk("txn_out_data", out_data, ct);
        chk("txn_d2_out_data", d2_out_data, ct);
        for (int unsigned d = 0; d < rdy; d++) begin
            tick();
            chk("bp_out_valid", DW'(out_valid), DW'(1));
            chk("bp_out_data", out_data, ct);
            chk("bp_in_ready", DW'(in_ready), '0);
            chk("bp_busy", DW'(busy), DW'(1));
            chk("bp_state", state, pt);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_cnt++;
        exp2 = exp_cnt[1:0];
        chk("txn_out_valid_cleared", DW'(out_valid), '0);
        chk("txn_blk_count", DW'(blk_count), DW'(exp_cnt));
        chk("txn_d2_blk_count", DW'(d2_blk_count), DW'(exp2));
        chk("txn_back_idle", DW'(in_ready), DW'(1));
        chk("txn_state_after", state, pt);
    endtask

    initial begin
        int unsigned cs;

        vecs[0] = '{pt: 128'h3243f6a8885a308d313198a2e0370734, k: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    ct: 128'h3925841d02dc09fbdc118597196a0b32, lat: 3, rdy: 0};
        vecs[1] = '{pt: 128'h00112233445566778899aabbccddeeff, k: 128'h000102030405060708090a0b0c0d0e0f,
                    ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, lat: 0, rdy: 10};
        vecs[2] = '{pt: {DW{1'b1}}, k: 128'h0,
                    ct: 128'hdeadbeef0badf00dcafef00d12345678, lat: 20, rdy: 1};
        vecs[3] = '{pt: 128'h80000000000000000000000000000001, k: {DW{1'b1}},
                    ct: 128'h0123456789abcdeffedcba9876543210, lat: 62, rdy: 3};
        sv[0] = 128'h0;
        sv[1] = 128'h1;
        sv[2] = 128'h00112233445566778899aabbccddeeff;
        sv[3] = 128'h2;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        in_key    = '0;
        core_done = 1'b0;
        core_out  = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk_reset("por");
        rst = 1'b0;
        exp_cnt = '0;

        // Table-driven transactions
        for (int unsigned v = 0; v < 4; v++) begin
            do_txn(vecs[v].pt, vecs[v].k, vecs[v].ct, vecs[v].lat, vecs[v].rdy);
        end

        // Watchdog: no core_done, abort after TIMEOUT cycles of WAIT
        in_state = vecs[0].pt;
        in_key   = vecs[0].k;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("wd_core_start", DW'(core_start), DW'(1));
        for (int unsigned c = 1; c <= TO; c++) begin
            tick();
            chk("wd_no_early_err", DW'(timeout_err), '0);
            chk("wd_busy", DW'(busy), DW'(1));
        end
        tick();
        chk("wd_err_pulse", DW'(timeout_err), DW'(1));
        chk("wd_idle", DW'(in_ready), DW'(1));
        chk("wd_no_out", DW'(out_valid), '0);
        chk("wd_blk_count", DW'(blk_count), DW'(exp_cnt));
        chk("wd_state_kept", state, vecs[0].pt);
        chk("wd_key_kept", key, vecs[0].k);
        tick();
        chk("wd_err_single", DW'(timeout_err), '0);
        chk("wd_state_still", state, vecs[0].pt);

        // Collision: done on the watchdog's final WAIT cycle
        in_state = vecs[1].pt;
        in_key   = vecs[1].k;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int unsigned c = 1; c < TO; c++) tick();
        tick();
        core_done = 1'b1;
        core_out  = vecs[1].ct;
        tick();
        core_done = 1'b0;
        chk("col_out_valid", DW'(out_valid), DW'(1));
        chk("col_out_data", out_data, vecs[1].ct);
        chk("col_no_err", DW'(timeout_err), '0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_cnt++;
        chk("col_blk_count", DW'(blk_count), DW'(exp_cnt));
        chk("col_no_err_after", DW'(timeout_err), '0);

        // Stream with in_valid held high
        pulse_reset();
        chk_reset("rst_idle");
        cs = 0;
        in_valid = 1'b1;
        in_state = sv[0];
        in_key   = vecs[0].k;
        for (int unsigned i = 0; i < 4; i++) begin
            tick();
            cs += 32'(core_start);
            chk("st_state_start", state, sv[i]);
            if (i == 3) in_valid = 1'b0;
            else        in_state = sv[i+1];
            tick();
            cs += 32'(core_start);
            chk("st_state_wait", state, sv[i]);
            core_done = 1'b1;
            core_out  = sv[i] ^ 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5;
            tick();
            core_done = 1'b0;
            cs += 32'(core_start);
            chk("st_out_data", out_data, sv[i] ^ 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5);
            chk("st_state_out", state, sv[i]);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            cs += 32'(core_start);
            exp_cnt++;
            chk("st_blk_count", DW'(blk_count), DW'(exp_cnt));
            chk("st_state_idle", state, sv[i]);
        end
        chk("st_start_pulses", DW'(cs), DW'(4));
        chk("st_final_count", DW'(blk_count), DW'(4));

        // Reset during WAIT, then a stray core_done
        in_state = vecs[2].pt;
        in_key   = vecs[2].k;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        pulse_reset();
        chk_reset("rst_wait");
        core_done = 1'b1;
        core_out  = vecs[2].ct;
        tick();
        core_done = 1'b0;
        chk("stray_done_out_valid", DW'(out_valid), '0);
        chk("stray_done_out_data", out_data, '0);
        chk("stray_done_err", DW'(timeout_err), '0);
        chk("stray_done_busy", DW'(busy), '0);

        // Reset during OUT
        in_state = vecs[3].pt;
        in_key   = vecs[3].k;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        core_done = 1'b1;
        core_out  = vecs[3].ct;
        tick();
        core_done = 1'b0;
        chk("pre_rst_out_valid", DW'(out_valid), DW'(1));
        pulse_reset();
        chk_reset("rst_out");

        // Counter wrap on the 2-bit instance: 5 blocks -> 1
        for (int unsigned b = 0; b < 5; b++) begin
            do_txn(sv[b % 4], vecs[b % 4].k, vecs[b % 4].ct, 1, 0);
        end
        chk("wrap_d2_count", DW'(d2_blk_count), DW'(1));
        chk("wrap_count16", DW'(blk_count), DW'(5));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
